half_sub_feeder: RTL and testbench
==================================

# half_sub_feeder

Upstream operand serializer for the bit-serial half-subtractor stage. Accepts two WIDTH-bit operand words via a valid/ready handshake, then drives one bit pair per clock onto in1/in2 (the minuend and subtrahend bits), with bit_valid, bit_last and bit_idx qualifiers. Supports back-to-back words with no idle cycle between them.

## Interface
- WIDTH, 8: operand width in bits. Legal range is WIDTH >= 2.
- MSB_FIRST, 0: bit order. 0 sends bit 0 first. 1 sends bit WIDTH-1 first.
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- op_valid  input  1  operand word available
- op_ready  output  1  feeder can accept a word this cycle
- op_a  input  WIDTH  minuend word; sampled on accept
- op_b  input  WIDTH  subtrahend word; sampled on accept
- in1  output  1  current minuend bit (registered)
- in2  output  1  current subtrahend bit (registered)
- bit_valid  output  1  in1/in2 carry a live bit this cycle
- bit_last  output  1  final bit of the current word; only high when bit_valid is high
- bit_idx  output  $clog2(WIDTH)  position of the current bit in the original word
- busy  output  1  a word is being shifted out

## Operation
- FSM has two states, IDLE and SHIFT.
- Reset state is IDLE. Reset values: in1=0, in2=0, bit_valid=0, bit_last=0, bit_idx=0, busy=0, internal shift registers=0, count=0.
- op_ready is combinational:
  - 0 while rst=1.
  - 1 in IDLE.
  - 1 in SHIFT only while bit_last=1.
  - 0 in SHIFT otherwise.
- Accept = op_valid & op_ready at a rising edge. On accept:
  - op_a and op_b are latched.
  - The first bit is loaded onto in1/in2 (bit 0, or bit WIDTH-1 if MSB_FIRST=1).
  - bit_valid=1, busy=1, bit_idx=first index, and the FSM enters or stays in SHIFT.
- In SHIFT without an accept, each edge advances one bit:
  - bit_idx increments (MSB_FIRST=0) or decrements (MSB_FIRST=1).
  - in1/in2 take the next bits.
- bit_last=1 exactly when the bit currently presented is the final one (index WIDTH-1, or 0 if MSB_FIRST=1).
- At the edge ending a bit_last cycle:
  - With an accept: the new word's first bit is presented next cycle. There is no bubble.
  - Without an accept: go to IDLE with bit_valid=0, bit_last=0, busy=0, in1=0, in2=0, bit_idx=0.
- op_a/op_b changes while not accepting have no effect on the bits in flight.
- rst=1 in any state forces the reset values at the next edge. A word in flight is discarded, with no partial bit_last.
- rst=1 and op_valid=1 in the same cycle: no accept.

## Timing
- Accept at edge k: the first bit is valid from after edge k until edge k+1.
- Bit i (in transmission order) is valid in cycle k+1+i. bit_last is high in cycle k+WIDTH.
- Latency from accept to first bit: 1 cycle. Throughput: one word per WIDTH cycles when op_valid is held high.
- busy equals bit_valid at all times.
- Outputs are registered. No combinational path from op_valid, op_a or op_b to in1, in2, bit_valid, bit_last or bit_idx.

## Test plan
- Reset, then op_valid=0 for 5 cycles -> op_ready=1, bit_valid=0, in1=in2=0, busy=0 throughout.
- WIDTH=8, MSB_FIRST=0, op_a=0xA5, op_b=0x3C, single accept:
  - in1 sequence 1,0,1,0,0,1,0,1.
  - in2 sequence 0,0,1,1,1,1,0,0.
  - bit_idx 0..7. bit_last only with idx 7. IDLE on the next cycle.
- MSB_FIRST=1, op_a=0x80, op_b=0x01 -> in1 = 1 then seven 0s; in2 = seven 0s then 1; bit_idx 7..0.
- Back-to-back, op_valid held high with words (0xFF,0x00) then (0x00,0xFF):
  - Accept occurs during the first word's bit_last cycle.
  - 16 contiguous bit_valid cycles with no gap.
  - in1 switches from 1 to 0 and in2 from 0 to 1 at cycle 9.
- op_valid asserted mid-word (bit_idx=3) -> op_ready=0 and no accept until the bit_last cycle. Bits of the current word are unchanged even if op_a/op_b change.
- rst pulsed for 1 cycle at bit_idx=4 -> next cycle: bit_valid=0, busy=0, bit_idx=0, in1=in2=0, and no bit_last was emitted for that word. A new word then streams correctly starting at idx 0.

Source files
------------

// File: rtl/half_sub_feeder.sv
// Operand serializer for the bit-serial half-subtractor: accepts a minuend/subtrahend word pair
// and presents one bit pair per clock, with back-to-back words joined without a bubble.
module half_sub_feeder #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      op_valid,
   output logic                      op_ready,
   input  logic [WIDTH-1:0]          op_a,
   input  logic [WIDTH-1:0]          op_b,
   output logic                      in1,
   output logic                      in2,
   output logic                      bit_valid,
   output logic                      bit_last,
   output logic [$clog2(WIDTH)-1:0]  bit_idx,
   output logic                      busy
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] FIRST_IDX   = MSB_FIRST ? IDX_W'(WIDTH - 1) : '0;
   localparam logic [IDX_W-1:0] PRELAST_CNT = IDX_W'(WIDTH - 2);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [IDX_W-1:0] count;
   logic             accept;

   // A new word may enter while idle or during the final bit of the word in flight.
   assign op_ready = !rst && ((state == IDLE) || bit_last);
   assign accept   = op_valid && op_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in1       <= 1'b0;
         in2       <= 1'b0;
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
         bit_idx   <= '0;
         busy      <= 1'b0;
         sh_a      <= '0;
         sh_b      <= '0;
         count     <= '0;
      end else if (accept) begin
         state     <= SHIFT;
         bit_valid <= 1'b1;
         busy      <= 1'b1;
         bit_last  <= 1'b0;
         bit_idx   <= FIRST_IDX;
         count     <= '0;
         // The first bit goes straight to the outputs; the shifters hold the remainder.
         if (MSB_FIRST) begin
            in1  <= op_a[WIDTH-1];
            in2  <= op_b[WIDTH-1];
            sh_a <= op_a << 1;
            sh_b <= op_b << 1;
         end else begin
            in1  <= op_a[0];
            in2  <= op_b[0];
            sh_a <= op_a >> 1;
            sh_b <= op_b >> 1;
         end
      end else if (state == SHIFT) begin
         if (bit_last) begin
            state     <= IDLE;
            in1       <= 1'b0;
            in2       <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            sh_a      <= '0;
            sh_b      <= '0;
            count     <= '0;
         end else begin
            count    <= count + 1'b1;
            bit_last <= (count == PRELAST_CNT);
            if (MSB_FIRST) begin
               bit_idx <= bit_idx - 1'b1;
               in1     <= sh_a[WIDTH-1];
               in2     <= sh_b[WIDTH-1];
               sh_a    <= sh_a << 1;
               sh_b    <= sh_b << 1;
            end else begin
               bit_idx <= bit_idx + 1'b1;
               in1     <= sh_a[0];
               in2     <= sh_b[0];
               sh_a    <= sh_a >> 1;
               sh_b    <= sh_b >> 1;
            end
         end
      end
   end

endmodule

// File: tb/tb_half_sub_feeder.sv
// Directed bench for half_sub_feeder: one LSB-first and one MSB-first instance, 8-bit words.
module tb_half_sub_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       op_valid = 1'b0, op_ready;
   logic [7:0] op_a = '0, op_b = '0;
   logic       in1, in2, bit_valid, bit_last, busy;
   logic [2:0] bit_idx;

   logic       m_op_valid = 1'b0, m_op_ready;
   logic [7:0] m_op_a = '0, m_op_b = '0;
   logic       m_in1, m_in2, m_bit_valid, m_bit_last, m_busy;
   logic [2:0] m_bit_idx;

   int n_checks = 0;
   int n_errors = 0;

   half_sub_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .in1(in1), .in2(in2), .bit_valid(bit_valid),
      .bit_last(bit_last), .bit_idx(bit_idx), .busy(busy)
   );

   half_sub_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .op_valid(m_op_valid), .op_ready(m_op_ready),
      .op_a(m_op_a), .op_b(m_op_b), .in1(m_in1), .in2(m_in2), .bit_valid(m_bit_valid),
      .bit_last(m_bit_last), .bit_idx(m_bit_idx), .busy(m_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks one full LSB-first word just accepted; op_valid must already be low.
   task automatic check_word(input string tag, input logic [7:0] ea, input logic [7:0] eb);
      for (int i = 0; i < 8; i++) begin
         check({tag, " in1"}, 32'(in1), 32'(ea[i]));
         check({tag, " in2"}, 32'(in2), 32'(eb[i]));
         check({tag, " idx"}, 32'(bit_idx), 32'(i));
         check({tag, " last"}, 32'(bit_last), 32'(i == 7));
         check({tag, " valid"}, 32'(bit_valid), 32'd1);
         check({tag, " busy"}, 32'(busy), 32'd1);
         step();
      end
      check({tag, " end valid"}, 32'(bit_valid), 32'd0);
      check({tag, " end busy"}, 32'(busy), 32'd0);
      check({tag, " end ready"}, 32'(op_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] exp1, exp2;
      logic       saw_last;
      int         waited;

      // Reset behaviour
      step();
      check("rst ready", 32'(op_ready), 32'd0);
      check("rst valid", 32'(bit_valid), 32'd0);
      check("rst m_idx", 32'(m_bit_idx), 32'd0);
      rst = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         check("idle ready", 32'(op_ready), 32'd1);
         check("idle valid", 32'(bit_valid), 32'd0);
         check("idle in", 32'({in1, in2}), 32'd0);
         check("idle busy", 32'(busy), 32'd0);
         check("idle idx", 32'(bit_idx), 32'd0);
         check("idle m_ready", 32'(m_op_ready), 32'd1);
         step();
      end

      // Single LSB-first word
      op_a = 8'hA5; op_b = 8'h3C; op_valid = 1'b1;
      step();
      op_valid = 1'b0;
      exp1 = 8'b1010_0101;
      exp2 = 8'b0011_1100;
      check_word("lsb", exp1, exp2);

      // Single MSB-first word: in1 = 1,0,0,0,0,0,0,0 ; in2 = 0,...,0,1
      m_op_a = 8'h80; m_op_b = 8'h01; m_op_valid = 1'b1;
      step();
      m_op_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("msb in1", 32'(m_in1), 32'(i == 0));
         check("msb in2", 32'(m_in2), 32'(i == 7));
         check("msb idx", 32'(m_bit_idx), 32'(7 - i));
         check("msb last", 32'(m_bit_last), 32'(i == 7));
         check("msb busy", 32'(m_busy), 32'd1);
         step();
      end
      check("msb end valid", 32'(m_bit_valid), 32'd0);
      check("msb end idx", 32'(m_bit_idx), 32'd0);

      // Back-to-back words with op_valid held high
      op_a = 8'hFF; op_b = 8'h00; op_valid = 1'b1;
      step();
      op_a = 8'h00; op_b = 8'hFF;
      for (int c = 0; c < 16; c++) begin
         check("b2b valid", 32'(bit_valid), 32'd1);
         check("b2b in1", 32'(in1), 32'(c < 8));
         check("b2b in2", 32'(in2), 32'(c >= 8));
         check("b2b idx", 32'(bit_idx), 32'(c % 8));
         check("b2b last", 32'(bit_last), 32'((c % 8) == 7));
         check("b2b ready", 32'(op_ready), 32'((c % 8) == 7));
         if (c == 15) op_valid = 1'b0;
         step();
      end
      check("b2b end valid", 32'(bit_valid), 32'd0);

      // Request mid-word is held off until bit_last; operand changes do not disturb bits
      op_a = 8'hC3; op_b = 8'h96; op_valid = 1'b1;
      step();
      op_valid = 1'b0;
      exp1 = 8'hC3;
      exp2 = 8'h96;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            op_valid = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
            #1;
         end
         check("mid in1", 32'(in1), 32'(exp1[i]));
         check("mid in2", 32'(in2), 32'(exp2[i]));
         check("mid idx", 32'(bit_idx), 32'(i));
         if (i >= 3) check("mid ready", 32'(op_ready), 32'(i == 7));
         step();
      end
      op_valid = 1'b0;
      check("mid next in", 32'({in1, in2}), 32'b11);
      check("mid next idx", 32'(bit_idx), 32'd0);
      check("mid next valid", 32'(bit_valid), 32'd1);
      waited = 0;
      while (bit_valid && waited < 20) begin
         step();
         waited++;
      end
      check("mid drain", 32'(bit_valid), 32'd0);

      // Reset pulse mid-word, with op_valid high during reset (no accept)
      op_a = 8'hA5; op_b = 8'h3C; op_valid = 1'b1;
      step();
      op_valid = 1'b0;
      saw_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         saw_last |= bit_last;
         step();
      end
      check("rstmid idx", 32'(bit_idx), 32'd4);
      saw_last |= bit_last;
      rst = 1'b1; op_valid = 1'b1;
      step();
      rst = 1'b0; op_valid = 1'b0;
      check("rstmid no last", 32'(saw_last), 32'd0);
      check("rstmid valid", 32'(bit_valid), 32'd0);
      check("rstmid busy", 32'(busy), 32'd0);
      check("rstmid idx0", 32'(bit_idx), 32'd0);
      check("rstmid in", 32'({in1, in2}), 32'd0);
      check("rstmid last", 32'(bit_last), 32'd0);
      step();
      check("rstmid idle", 32'(bit_valid), 32'd0);
      op_a = 8'h3C; op_b = 8'hA5; op_valid = 1'b1;
      step();
      op_valid = 1'b0;
      exp1 = 8'b0011_1100;
      exp2 = 8'b1010_0101;
      check_word("post", exp1, exp2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
